riscv_mem_arbiter: RTL and testbench
====================================

RISCV_MEM_ARBITER -- requirements
Module: riscv_mem_arbiter

Interface
REQ-001 Parameter: STARVE_MAX, default 4, meaning the number of consecutive data grants allowed while a fetch waits (range 1-15).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 if_req  input  1  instruction-fetch request; held until if_gnt.
REQ-005 if_addr  input  32  fetch byte address.
REQ-006 if_gnt  output  1  fetch request accepted this cycle.
REQ-007 if_rvalid  output  1  one-cycle pulse; if_rdata is valid.
REQ-008 if_rdata  output  32  fetched instruction word.
REQ-009 d_req  input  1  data request; held until d_gnt.
REQ-010 d_we  input  1  1 = store, 0 = load.
REQ-011 d_addr  input  32  data byte address.
REQ-012 d_wdata  input  32  store data.
REQ-013 d_be  input  4  store byte enables.
REQ-014 d_gnt  output  1  data request accepted this cycle.
REQ-015 d_rvalid  output  1  one-cycle completion pulse for loads and stores.
REQ-016 d_rdata  output  32  load data; 0 for store completions.
REQ-017 mem_req  output  1  unified memory request, held until mem_ack.
REQ-018 mem_we, mem_addr[31:0], mem_wdata[31:0], mem_be[3:0]  output  request attributes, stable while mem_req=1.
REQ-019 mem_ack  input  1  memory completes the current request this cycle (latency ≥1 cycle, unbounded).
REQ-020 mem_rdata  input  32  read data, valid when mem_ack=1.

Function
REQ-021 The FSM SHALL have exactly three states: IDLE, BUSY_I and BUSY_D, with only one transaction outstanding.
REQ-022 In IDLE with any request pending, the arbiter SHALL assert exactly one gnt combinationally in that cycle and SHALL capture the attributes at the clock edge, entering BUSY_I or BUSY_D.
REQ-023 Priority SHALL go to data unless starve_cnt == STARVE_MAX with if_req=1; in that case fetch SHALL win.
REQ-024 starve_cnt (4 bits) SHALL increment on each d_gnt while if_req=1, saturate at STARVE_MAX, and clear on if_gnt.
REQ-025 In BUSY states, mem_req SHALL be 1 with latched attributes; no gnt SHALL be issued.
REQ-026 mem_addr SHALL be the latched address with bits [1:0] forced to 0.
REQ-027 Fetch transactions SHALL drive mem_we=0, mem_be=4'hF and mem_wdata=0.
REQ-028 On mem_ack in a BUSY state, the FSM SHALL return to IDLE and mem_req SHALL drop in the next cycle.
REQ-029 The owner's rvalid SHALL pulse for exactly one cycle, in the cycle after mem_ack, with rdata registered from mem_rdata (loads/fetch) or 0 (stores).
REQ-030 A new grant SHALL be allowed in the same cycle as the rvalid pulse, giving a minimum 2-cycle gap from mem_ack to the next mem_req.
REQ-031 mem_ack while IDLE SHALL be ignored and SHALL produce no rvalid.
REQ-032 Request inputs SHALL be sampled only in IDLE; changes during BUSY SHALL have no effect on the current transaction.
REQ-033 rdata outputs SHALL hold their last value between rvalid pulses.

Reset
REQ-034 While rst_n=0: state=IDLE, starve_cnt=0, all outputs 0, including mem_req, gnts, rvalids, rdata and mem attributes.
REQ-035 Reset asserted mid-transaction SHALL abort it immediately with no rvalid; a mem_ack arriving after release SHALL be ignored.
REQ-036 The first grant SHALL be possible in the first clock edge after rst_n rises.

Verification
REQ-037 Fetch only: if_req, if_addr=0x0000_0106, mem_ack 3 cycles after mem_req with rdata=0x0010_0093 -> mem_addr=0x104, mem_be=F, if_rvalid one cycle after ack, if_rdata=0x0010_0093.
REQ-038 Simultaneous if_req and d_req (load 0x200), starve_cnt=0 -> d_gnt first, if_gnt in the cycle of d_rvalid, starve_cnt=0 afterwards.
REQ-039 d_req held continuously with if_req, STARVE_MAX=4 -> exactly 4 data grants, then 1 fetch grant, then data resumes.
REQ-040 Store d_addr=0x300, d_wdata=0xDEADBEEF, d_be=4'b0011 -> mem_we=1 with attributes stable until ack, d_rvalid pulse with d_rdata=0.
REQ-041 rst_n low during BUSY_D, ack after release -> no d_rvalid, mem_req=0, next request granted normally.
REQ-042 Spurious mem_ack in IDLE -> no rvalid and no state change.

Source files
------------

// File: rtl/riscv_mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single-outstanding unified memory port.
// Data has priority; a starvation counter forces a fetch grant after STARVE_MAX data grants.
module riscv_mem_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_be,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {StIdle, StBusyI, StBusyD} state_e;

    localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

    state_e      state_q, state_d;
    logic [3:0]  starve_q, starve_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        if_rvalid_q, if_rvalid_d;
    logic        d_rvalid_q, d_rvalid_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        fetch_win, data_win;

    // Word-aligned memory port: the low address bits are never forwarded.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[1:0], d_addr[1:0]};

    always_comb begin
        fetch_win   = if_req && (!d_req || (starve_q == StarveMax));
        data_win    = d_req && !fetch_win;
        state_d     = state_q;
        starve_d    = starve_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        if_rvalid_d = 1'b0;
        d_rvalid_d  = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_gnt      = 1'b0;
        d_gnt       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (fetch_win) begin
                    // Gated by rst_n so grants stay low while reset is held.
                    if_gnt  = rst_n;
                    state_d = StBusyI;
                    we_d    = 1'b0;
                    addr_d  = {if_addr[31:2], 2'b00};
                    wdata_d = 32'h0;
                    be_d    = 4'hF;
                end else if (data_win) begin
                    d_gnt   = rst_n;
                    state_d = StBusyD;
                    we_d    = d_we;
                    addr_d  = {d_addr[31:2], 2'b00};
                    wdata_d = d_wdata;
                    be_d    = d_be;
                end
            end
            StBusyI: begin
                if (mem_ack) begin
                    state_d     = StIdle;
                    if_rvalid_d = 1'b1;
                    if_rdata_d  = mem_rdata;
                end
            end
            StBusyD: begin
                if (mem_ack) begin
                    state_d    = StIdle;
                    d_rvalid_d = 1'b1;
                    d_rdata_d  = we_q ? 32'h0 : mem_rdata;
                end
            end
            default: state_d = StIdle;
        endcase

        if (if_gnt) begin
            starve_d = 4'h0;
        end else if (d_gnt && if_req && (starve_q < StarveMax)) begin
            starve_d = starve_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            starve_q    <= 4'h0;
            we_q        <= 1'b0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            be_q        <= 4'h0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            if_rdata_q  <= 32'h0;
            d_rdata_q   <= 32'h0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            if_rvalid_q <= if_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign mem_req   = (state_q != StIdle);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_be    = be_q;
    assign if_rvalid = if_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign d_rvalid  = d_rvalid_q;
    assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Directed bench for riscv_mem_arbiter: fetch, load, store, starvation, spurious ack,
// and mid-transaction reset.
module tb_riscv_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int n_assert = 0;
    int n_fail   = 0;
    logic [5:0] exp_fetch;

    riscv_mem_arbiter #(.STARVE_MAX(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_be      (d_be),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        if_req    = 1'b1;
        if_addr   = 32'h0000_0106;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_addr    = 32'h0;
        d_wdata   = 32'h0;
        d_be      = 4'h0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        exp_fetch = 6'b010000;

        // Reset: all outputs low even with a request pending
        repeat (2) @(posedge clk);
        #1;
        chk("rst_if_gnt", if_gnt, 0);
        chk("rst_d_gnt", d_gnt, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_be", mem_be, 0);
        chk("rst_if_rvalid", if_rvalid, 0);
        chk("rst_d_rvalid", d_rvalid, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        chk("rst_starve", dut.starve_q, 0);

        // Fetch only; first grant at first edge after release
        rst_n = 1'b1;
        #1;
        chk("f_if_gnt", if_gnt, 1);
        chk("f_d_gnt", d_gnt, 0);
        tick();
        if_req  = 1'b0;
        if_addr = 32'h0000_0FF0;
        #1;
        chk("f_mem_req", mem_req, 1);
        chk("f_mem_addr", mem_addr, 32'h104);
        chk("f_mem_be", mem_be, 4'hF);
        chk("f_mem_we", mem_we, 0);
        chk("f_mem_wdata", mem_wdata, 0);
        chk("f_busy_gnt", if_gnt, 0);
        tick();
        tick();
        chk("f_addr_stable", mem_addr, 32'h104);
        mem_ack   = 1'b1;
        mem_rdata = 32'h0010_0093;
        #1;
        chk("f_no_early_rvalid", if_rvalid, 0);
        tick();
        mem_ack = 1'b0;
        chk("f_if_rvalid", if_rvalid, 1);
        chk("f_if_rdata", if_rdata, 32'h0010_0093);
        chk("f_mem_req_drop", mem_req, 0);
        chk("f_d_rvalid", d_rvalid, 0);
        tick();
        chk("f_rvalid_pulse", if_rvalid, 0);
        chk("f_rdata_hold", if_rdata, 32'h0010_0093);

        // Simultaneous fetch and load: data first, fetch in the rvalid cycle
        if_req  = 1'b1;
        if_addr = 32'h0000_0040;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 32'h0000_0200;
        #1;
        chk("s_d_gnt", d_gnt, 1);
        chk("s_if_gnt", if_gnt, 0);
        tick();
        d_req = 1'b0;
        #1;
        chk("s_busy_if_gnt", if_gnt, 0);
        chk("s_mem_addr", mem_addr, 32'h200);
        chk("s_mem_we", mem_we, 0);
        chk("s_starve1", dut.starve_q, 1);
        mem_ack   = 1'b1;
        mem_rdata = 32'h1111_2222;
        tick();
        mem_ack = 1'b0;
        #1;
        chk("s_d_rvalid", d_rvalid, 1);
        chk("s_d_rdata", d_rdata, 32'h1111_2222);
        chk("s_if_gnt_rv", if_gnt, 1);
        tick();
        if_req = 1'b0;
        chk("s_if_mem_addr", mem_addr, 32'h40);
        chk("s_starve0", dut.starve_q, 0);
        mem_ack   = 1'b1;
        mem_rdata = 32'h3333_4444;
        tick();
        mem_ack = 1'b0;
        chk("s_if_rvalid", if_rvalid, 1);
        chk("s_if_rdata", if_rdata, 32'h3333_4444);
        chk("s_d_rvalid_off", d_rvalid, 0);

        // Starvation: 4 data grants, 1 fetch grant, then data again
        if_req    = 1'b1;
        if_addr   = 32'h0000_0080;
        d_req     = 1'b1;
        d_addr    = 32'h0000_0400;
        mem_rdata = 32'hCAFE_0001;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk($sformatf("st_d_gnt%0d", k), d_gnt, {31'h0, ~exp_fetch[k]});
            chk($sformatf("st_if_gnt%0d", k), if_gnt, {31'h0, exp_fetch[k]});
            tick();
            mem_ack = 1'b1;
            tick();
            mem_ack = 1'b0;
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        chk("st_if_rdata", if_rdata, 32'hCAFE_0001);

        // Store; inputs changing during BUSY must not affect the transaction
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h0000_0300;
        d_wdata = 32'hDEAD_BEEF;
        d_be    = 4'b0011;
        #1;
        chk("w_d_gnt", d_gnt, 1);
        tick();
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = 32'h0000_0FFF;
        d_wdata = 32'h0;
        d_be    = 4'hF;
        #1;
        chk("w_mem_we", mem_we, 1);
        chk("w_mem_addr", mem_addr, 32'h300);
        chk("w_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        chk("w_mem_be", mem_be, 4'b0011);
        tick();
        chk("w_we_stable", mem_we, 1);
        chk("w_wdata_stable", mem_wdata, 32'hDEAD_BEEF);
        chk("w_be_stable", mem_be, 4'b0011);
        mem_ack   = 1'b1;
        mem_rdata = 32'hAAAA_5555;
        tick();
        mem_ack = 1'b0;
        chk("w_d_rvalid", d_rvalid, 1);
        chk("w_d_rdata", d_rdata, 0);
        chk("w_mem_req", mem_req, 0);
        tick();
        chk("w_rvalid_pulse", d_rvalid, 0);

        // Spurious ack while idle
        mem_ack   = 1'b1;
        mem_rdata = 32'h1234_5678;
        tick();
        mem_ack = 1'b0;
        chk("sp_d_rvalid", d_rvalid, 0);
        chk("sp_if_rvalid", if_rvalid, 0);
        chk("sp_mem_req", mem_req, 0);
        chk("sp_if_rdata", if_rdata, 32'hCAFE_0001);
        tick();
        chk("sp_mem_req2", mem_req, 0);

        // Reset in BUSY_D, ack after release is ignored
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h0000_0500;
        tick();
        d_req = 1'b0;
        chk("r_mem_req", mem_req, 1);
        chk("r_mem_addr", mem_addr, 32'h500);
        rst_n = 1'b0;
        #1;
        chk("r_abort_mem_req", mem_req, 0);
        chk("r_abort_addr", mem_addr, 0);
        chk("r_abort_rdata", d_rdata, 0);
        tick();
        rst_n     = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 32'h5555_6666;
        tick();
        mem_ack = 1'b0;
        chk("r_no_d_rvalid", d_rvalid, 0);
        chk("r_mem_req_idle", mem_req, 0);
        if_req  = 1'b1;
        if_addr = 32'h0000_0008;
        #1;
        chk("r_if_gnt", if_gnt, 1);
        tick();
        if_req = 1'b0;
        chk("r_if_mem_addr", mem_addr, 32'h8);
        mem_ack   = 1'b1;
        mem_rdata = 32'h7777_8888;
        tick();
        mem_ack = 1'b0;
        chk("r_if_rvalid", if_rvalid, 1);
        chk("r_if_rdata", if_rdata, 32'h7777_8888);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
